mimo_phase_sched: RTL and testbench

MIMO_PHASE_SCHED -- requirements
Module: mimo_phase_sched

---
 rtl/mimo_phase_sched.sv | 126 ++++++++++++
 tb/tb_mimo_phase_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mimo_phase_sched.sv
// Round-robin scheduler that time-shares one detector datapath between N_REQ streams.
// Each granted stream is walked through LOAD, CALC and DRAIN before the next grant.
module mimo_phase_sched #(
    parameter int N_REQ     = 4,
    parameter int LOAD_CYC  = 4,
    parameter int CALC_CYC  = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     abort,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [1:0]               phase,
    output logic                     ld_en,
    output logic                     calc_en,
    output logic                     drain_en,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id
);
    // state   | meaning
    // S_IDLE  | no owner, waiting for any req
    // S_LOAD  | owner's operands loading, LOAD_CYC cycles
    // S_CALC  | detector computing, CALC_CYC cycles
    // S_DRAIN | results draining, DRAIN_CYC cycles; last cycle raises done

    localparam int IDW     = $clog2(N_REQ);
    localparam int MAX_LC  = (LOAD_CYC > CALC_CYC) ? LOAD_CYC : CALC_CYC;
    localparam int MAX_CYC = (MAX_LC > DRAIN_CYC) ? MAX_LC : DRAIN_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]    LOAD_TC  = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0]    CALC_TC  = CW'(CALC_CYC - 1);
    localparam logic [CW-1:0]    DRAIN_TC = CW'(DRAIN_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CALC  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDW-1:0]   gid_q;
    logic [IDW-1:0]   last_q;

    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic             last_cyc;
    logic             start;

    // Scan from the farthest candidate back to last+1 so the nearest asserted request wins.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] last);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (r[IDW'(idx)]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {pick_vld, pick_id} = rr_pick(req, last_q);

    assign last_cyc = (state_q == S_DRAIN) && (cnt_q == '0);
    assign start    = pick_vld && ((state_q == S_IDLE) || (last_cyc && !abort));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IDW'(N_REQ - 1);
        end else if (state_q != S_IDLE && abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            gid_q   <= '0;
        end else if (start) begin
            state_q <= S_LOAD;
            cnt_q   <= LOAD_TC;
            grant_q <= ONE_HOT0 << pick_id;
            gid_q   <= pick_id;
            last_q  <= pick_id;
        end else if (state_q != S_IDLE) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        state_q <= S_CALC;
                        cnt_q   <= CALC_TC;
                    end
                    S_CALC: begin
                        state_q <= S_DRAIN;
                        cnt_q   <= DRAIN_TC;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        gid_q   <= '0;
                    end
                endcase
            end
        end
    end

    // done is visible throughout the final DRAIN cycle; abort at that edge only blocks the follow-on grant.
    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign phase    = state_q;
    assign ld_en    = (state_q == S_LOAD);
    assign calc_en  = (state_q == S_CALC);
    assign drain_en = (state_q == S_DRAIN);
    assign busy     = (state_q != S_IDLE);
    assign done     = last_cyc;
    assign done_id  = last_cyc ? gid_q : '0;

endmodule

// File: tb/tb_mimo_phase_sched.sv
// Bench for mimo_phase_sched: a default instance and an N_REQ=2 / 1-cycle-phase instance,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_mimo_phase_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic [3:0] req;
    logic [1:0] req1;

    logic [3:0] g0;
    logic [1:0] gid0, ph0, did0;
    logic       ld0, ca0, dr0, bz0, dn0;
    logic [1:0] g1, ph1;
    logic [0:0] gid1, did1;
    logic       ld1, ca1, dr1, bz1, dn1;

    int total = 0;
    int bad   = 0;

    mimo_phase_sched #(.N_REQ(4), .LOAD_CYC(4), .CALC_CYC(8), .DRAIN_CYC(2)) u0 (
        .clk(clk), .reset(reset), .req(req), .abort(abort),
        .grant(g0), .grant_id(gid0), .phase(ph0), .ld_en(ld0), .calc_en(ca0),
        .drain_en(dr0), .busy(bz0), .done(dn0), .done_id(did0)
    );

    mimo_phase_sched #(.N_REQ(2), .LOAD_CYC(1), .CALC_CYC(1), .DRAIN_CYC(1)) u1 (
        .clk(clk), .reset(reset), .req(req1), .abort(1'b0),
        .grant(g1), .grant_id(gid1), .phase(ph1), .ld_en(ld1), .calc_en(ca1),
        .drain_en(dr1), .busy(bz1), .done(dn1), .done_id(did1)
    );

    initial forever #5 clk = ~clk;

    // Transaction-level model: per instance, whether a stream owns the datapath, which one,
    // and how many cycles into its transaction we are (1..LOAD+CALC+DRAIN).
    int pN[2] = '{4, 2};
    int pL[2] = '{4, 1};
    int pC[2] = '{8, 1};
    int pD[2] = '{2, 1};
    int m_act[2]  = '{0, 0};
    int m_t[2]    = '{0, 0};
    int m_own[2]  = '{0, 0};
    int m_last[2] = '{3, 1};

    function automatic int rr_next(input logic [3:0] r, input int last, input int n);
        int c;
        c = last;
        for (int k = 0; k < n; k++) begin
            c = (c + 1 == n) ? 0 : c + 1;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] req_of(input int i);
        return (i == 0) ? req : {2'b00, req1};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  <= 0;
                m_t[i]    <= 0;
                m_own[i]  <= 0;
                m_last[i] <= pN[i] - 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] != 0 && i == 0 && abort) begin
                    m_act[i] <= 0;
                end else if (m_act[i] == 0 || m_t[i] == pL[i] + pC[i] + pD[i]) begin
                    if (rr_next(req_of(i), m_last[i], pN[i]) >= 0) begin
                        m_act[i]  <= 1;
                        m_t[i]    <= 1;
                        m_own[i]  <= rr_next(req_of(i), m_last[i], pN[i]);
                        m_last[i] <= rr_next(req_of(i), m_last[i], pN[i]);
                    end else begin
                        m_act[i] <= 0;
                    end
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i);
        int          tot, ph, eg;
        bit          a, ed;
        logic [31:0] ag, agid, aph, ald, aca, adr, abz, adn, adid;
        string       p;
        p   = (i == 0) ? "u0" : "u1";
        a   = (m_act[i] != 0);
        tot = pL[i] + pC[i] + pD[i];
        if (!a) ph = 0;
        else if (m_t[i] <= pL[i]) ph = 1;
        else if (m_t[i] <= pL[i] + pC[i]) ph = 2;
        else ph = 3;
        eg = a ? (1 << m_own[i]) : 0;
        ed = a && (m_t[i] == tot);
        if (i == 0) begin
            ag = 32'(g0); agid = 32'(gid0); aph = 32'(ph0); ald = 32'(ld0); aca = 32'(ca0);
            adr = 32'(dr0); abz = 32'(bz0); adn = 32'(dn0); adid = 32'(did0);
        end else begin
            ag = 32'(g1); agid = 32'(gid1); aph = 32'(ph1); ald = 32'(ld1); aca = 32'(ca1);
            adr = 32'(dr1); abz = 32'(bz1); adn = 32'(dn1); adid = 32'(did1);
        end
        chk({p, ".busy"}, abz, 32'(a));
        chk({p, ".phase"}, aph, ph);
        chk({p, ".ld_en"}, ald, 32'(ph == 1));
        chk({p, ".calc_en"}, aca, 32'(ph == 2));
        chk({p, ".drain_en"}, adr, 32'(ph == 3));
        chk({p, ".grant"}, ag, eg);
        chk({p, ".done"}, adn, 32'(ed));
        if (a) chk({p, ".grant_id"}, agid, m_own[i]);
        if (ed) chk({p, ".done_id"}, adid, m_own[i]);
    endtask

    always @(negedge clk) begin
        chk_inst(0);
        chk_inst(1);
    end

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nld, ncalc, ndr, dcyc, did, nd, gap;
        int dc[8];
        int di[8];
        reset = 1'b1; abort = 1'b0; req = 4'b0; req1 = 2'b0;

        // Reset state
        @(negedge clk);
        chk("rst.grant", 32'(g0), 0);
        chk("rst.grant_id", 32'(gid0), 0);
        chk("rst.phase", 32'(ph0), 0);
        chk("rst.busy", 32'(bz0), 0);
        chk("rst.done", 32'(dn0), 0);
        @(negedge clk);
        reset = 1'b0;

        // Single one-cycle request from stream 2
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        chk("single.grant", 32'(g0), 4);
        chk("single.grant_id", 32'(gid0), 2);
        nld = 0; ncalc = 0; ndr = 0; dcyc = -1; did = -1;
        for (int c = 1; c <= 16; c++) begin
            nld += int'(ld0); ncalc += int'(ca0); ndr += int'(dr0);
            if (dn0) begin dcyc = c; did = int'(did0); end
            @(negedge clk);
        end
        chk("single.ld_cycles", nld, 4);
        chk("single.calc_cycles", ncalc, 8);
        chk("single.drain_cycles", ndr, 2);
        chk("single.done_cycle", dcyc, 14);
        chk("single.done_id", did, 2);
        chk("single.idle_after", 32'(bz0), 0);

        // All four streams held: back-to-back rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        nd = 0; gap = 0;
        for (int c = 1; c <= 70; c++) begin
            if (!bz0) gap++;
            if (dn0 && nd < 8) begin dc[nd] = c; di[nd] = int'(did0); nd++; end
            if (c == 70) req = 4'b0000;
            @(negedge clk);
        end
        chk("all.done_count", nd, 5);
        chk("all.busy_gaps", gap, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("all.done_id[%0d]", k), di[k], k % 4);
            chk($sformatf("all.done_cycle[%0d]", k), dc[k], 14 * (k + 1));
        end
        chk("all.idle_after", 32'(bz0), 0);

        // Abort stream 1 in its third CALC cycle with req=0011 held
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        nd = 0; did = -1;
        for (int c = 1; c <= 21; c++) begin
            if (dn0) begin nd++; did = int'(did0); end
            if (c == 21) begin
                chk("abort.phase_at_abort", 32'(ph0), 2);
                chk("abort.owner_at_abort", 32'(gid0), 1);
                abort = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        chk("abort.idle", 32'(bz0), 0);
        chk("abort.no_done", 32'(dn0), 0);
        chk("abort.done_count", nd, 1);
        chk("abort.first_done_id", did, 0);
        @(negedge clk);
        chk("abort.next_grant", 32'(g0), 1);
        chk("abort.next_grant_id", 32'(gid0), 0);
        abort = 1'b1; req = 4'b0000;
        @(negedge clk);
        abort = 1'b0;

        // Asynchronous reset in the middle of CALC
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        chk("rstmid.in_calc", 32'(ph0), 2);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.grant", 32'(g0), 0);
        chk("rstmid.grant_id", 32'(gid0), 0);
        chk("rstmid.phase", 32'(ph0), 0);
        chk("rstmid.ld_en", 32'(ld0), 0);
        chk("rstmid.calc_en", 32'(ca0), 0);
        chk("rstmid.drain_en", 32'(dr0), 0);
        chk("rstmid.busy", 32'(bz0), 0);
        chk("rstmid.done", 32'(dn0), 0);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        chk("rstmid.regrant", 32'(g0), 8);
        chk("rstmid.regrant_id", 32'(gid0), 3);
        abort = 1'b1; req = 4'b0000;
        @(negedge clk);
        abort = 1'b0;

        // Abort coinciding with the last DRAIN cycle: IDLE instead of a direct re-grant
        req = 4'b0001;
        @(negedge clk);
        for (int c = 1; c <= 14; c++) begin
            if (c == 14) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        chk("abortdone.idle", 32'(bz0), 0);
        chk("abortdone.phase", 32'(ph0), 0);
        chk("abortdone.no_done", 32'(dn0), 0);
        @(negedge clk);
        chk("abortdone.regrant", 32'(g0), 1);
        req = 4'b0000; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Two streams, one cycle per phase, continuous requests
        req1 = 2'b11;
        @(negedge clk);
        nd = 0; gap = 0;
        for (int c = 1; c <= 12; c++) begin
            if (!bz1) gap++;
            if (dn1 && nd < 8) begin dc[nd] = c; di[nd] = int'(did1); nd++; end
            if (c == 12) req1 = 2'b00;
            @(negedge clk);
        end
        chk("sweep.done_count", nd, 4);
        chk("sweep.busy_gaps", gap, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep.done_id[%0d]", k), di[k], k % 2);
            chk($sformatf("sweep.done_cycle[%0d]", k), dc[k], 3 * (k + 1));
        end
        chk("sweep.idle_after", 32'(bz1), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
